fifo_ptr_ctrl_drop: RTL and testbench

Synchronous FIFO pointer controller. Manages the write/read pointers, occupancy count and full/empty flags for any DEPTH, including non-power-of-2 depths, using a lap-bit encoding. Adds drop-by-count, drop-all and flush operations with defined same-cycle interactions. It sits between the producer/consumer handshakes and a dual-port RAM; it addresses the RAM but holds no storage.

---
 rtl/fifo_ptr_pkg.sv | 37 +++
 rtl/fifo_ptr_adv.sv | 29 ++
 rtl/fifo_ptr_ctrl_drop.sv | 181 ++++++++++++++++++
 tb/tb_fifo_ptr_ctrl_drop.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ptr_pkg.sv
// Shared types and helpers for the FIFO pointer controller.
//   state_e   : drop acknowledge FSM states
//   ptr_diff  : occupancy implied by a write/read pointer pair (lap-bit encoded)
package fifo_ptr_pkg;

  typedef enum logic {
    ST_RUN,
    ST_DROP_ACK
  } state_e;

  // Widest pointer needed for the largest supported depth (65536 entries).
  localparam int unsigned MaxPtrW = 17;

  // Pointers are zero-extended to MaxPtrW. The lap bit sits just above the
  // address field, whose width is derived from depth the same way the RTL does.
  function automatic int unsigned ptr_diff(input logic [MaxPtrW-1:0] wr,
                                           input logic [MaxPtrW-1:0] rd,
                                           input int unsigned        depth);
    int unsigned addr_w;
    int unsigned lo_mod;
    int unsigned wv;
    int unsigned rv;
    int unsigned wlo;
    int unsigned rlo;
    addr_w = ($clog2(depth) > 1) ? $clog2(depth) : 1;
    lo_mod = 32'd1 << addr_w;
    wv     = 32'(wr);
    rv     = 32'(rd);
    wlo    = wv % lo_mod;
    rlo    = rv % lo_mod;
    if (((wv >> addr_w) & 32'd1) == ((rv >> addr_w) & 32'd1)) begin
      return wlo - rlo;
    end
    return depth + wlo - rlo;
  endfunction

endpackage

// File: rtl/fifo_ptr_adv.sv
// Combinational lap-bit pointer advance.
//   ptr      : current pointer, MSB is the lap bit, low bits in 0..DEPTH-1
//   n        : advance amount, 0..DEPTH
//   ptr_next : advanced pointer; the lap bit toggles when the low field wraps
module fifo_ptr_adv #(
  parameter int unsigned DEPTH = 10,
  parameter int unsigned PTR_W = 5
) (
  input  logic [PTR_W-1:0]               ptr,
  input  logic [$clog2(DEPTH+1)-1:0]     n,
  output logic [PTR_W-1:0]               ptr_next
);

  localparam int unsigned ADDR_W = PTR_W - 1;
  localparam logic [ADDR_W:0] DepthS = (ADDR_W+1)'(DEPTH);

  // One extra bit holds lo + n without overflow since lo < DEPTH and n <= DEPTH.
  logic [ADDR_W:0] sum;

  always_comb begin
    sum = {1'b0, ptr[ADDR_W-1:0]} + (ADDR_W+1)'(n);
    if (sum >= DepthS) begin
      ptr_next = {~ptr[PTR_W-1], ADDR_W'(sum - DepthS)};
    end else begin
      ptr_next = {ptr[PTR_W-1], sum[ADDR_W-1:0]};
    end
  end

endmodule

// File: rtl/fifo_ptr_ctrl_drop.sv
// Synchronous FIFO pointer controller with drop-by-count, drop-all and flush.
// Addresses an external dual-port RAM; holds no data storage itself.
//   wr_valid/wr_ready   : producer handshake
//   rd_valid/rd_ready   : consumer handshake
//   drop_valid/drop_all/drop_count : discard oldest entries (always accepted)
//   flush               : reset both pointers to 0
//   wr_addr/rd_addr     : RAM addresses (pointer low bits)
//   wr_ptr/rd_ptr       : registered lap-bit pointers
//   count/full/empty/almost_full : registered occupancy and flags
//   drop_done/dropped_cnt : one-cycle acknowledge after a drop
module fifo_ptr_ctrl_drop
  import fifo_ptr_pkg::*;
#(
  parameter int unsigned DEPTH     = 10,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  localparam int unsigned ADDR_W   = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned PTR_W    = ADDR_W + 1,
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              rd_ready,
  output logic              rd_valid,
  input  logic              drop_valid,
  input  logic              drop_all,
  input  logic [CNT_W-1:0]  drop_count,
  input  logic              flush,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              drop_done,
  output logic [CNT_W-1:0]  dropped_cnt
);

  localparam logic [CNT_W:0] DepthC = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W:0] AfThrC = (CNT_W+1)'(AF_THRESH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_adv;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, rd_ptr_adv;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] dropped_cnt_q, dropped_cnt_d;
  logic [CNT_W-1:0] drop_n, wr_step, rd_step;
  logic [CNT_W:0]   count_next;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             af_q, af_d;
  logic             drop_done_q, drop_done_d;
  logic             wr_fire, rd_fire, drop_fire;
  state_e           state_q, state_d;

  assign wr_ready  = !full_q && !flush;
  // A drop in flight hides the head entry so a read cannot race the discard.
  assign rd_valid  = !empty_q && !flush && !drop_valid;
  assign wr_fire   = wr_valid && wr_ready;
  assign rd_fire   = rd_ready && rd_valid;
  assign drop_fire = drop_valid && !flush;

  // Entries actually discarded this cycle, clamped to current occupancy.
  always_comb begin
    drop_n = '0;
    if (drop_fire) begin
      if (drop_all) begin
        drop_n = count_q;
      end else if (drop_count < count_q) begin
        drop_n = drop_count;
      end else begin
        drop_n = count_q;
      end
    end
  end

  assign wr_step = CNT_W'(wr_fire);
  assign rd_step = drop_fire ? drop_n : CNT_W'(rd_fire);

  fifo_ptr_adv #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_wr_adv (
    .ptr      (wr_ptr_q),
    .n        (wr_step),
    .ptr_next (wr_ptr_adv)
  );

  fifo_ptr_adv #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_rd_adv (
    .ptr      (rd_ptr_q),
    .n        (rd_step),
    .ptr_next (rd_ptr_adv)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_adv;
    rd_ptr_d   = rd_ptr_adv;
    count_next = {1'b0, count_q} + (CNT_W+1)'(wr_fire) - (CNT_W+1)'(rd_fire) - {1'b0, drop_n};
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_next = '0;
    end else if (drop_fire && drop_all) begin
      rd_ptr_d = wr_ptr_q;
    end
    count_d = count_next[CNT_W-1:0];
    full_d  = (count_next == DepthC);
    empty_d = (count_next == '0);
    af_d    = (count_next >= AfThrC);
  end

  always_comb begin
    state_d       = state_q;
    dropped_cnt_d = dropped_cnt_q;
    unique case (state_q)
      ST_RUN:      if (drop_fire) state_d = ST_DROP_ACK;
      ST_DROP_ACK: if (!drop_fire) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
    if (drop_fire) begin
      dropped_cnt_d = drop_n;
    end
    if (flush) begin
      state_d       = ST_RUN;
      dropped_cnt_d = '0;
    end
    drop_done_d = (state_d == ST_DROP_ACK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      drop_done_q   <= 1'b0;
      dropped_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      drop_done_q   <= drop_done_d;
      dropped_cnt_q <= dropped_cnt_d;
    end
  end

  assign wr_addr     = wr_ptr_q[ADDR_W-1:0];
  assign rd_addr     = rd_ptr_q[ADDR_W-1:0];
  assign wr_ptr      = wr_ptr_q;
  assign rd_ptr      = rd_ptr_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign drop_done   = drop_done_q;
  assign dropped_cnt = dropped_cnt_q;

  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
    32'(count_q) == ptr_diff(MaxPtrW'(wr_ptr_q), MaxPtrW'(rd_ptr_q), DEPTH));
  a_ptr_lo_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    (32'(wr_ptr_q[ADDR_W-1:0]) < DEPTH) && (32'(rd_ptr_q[ADDR_W-1:0]) < DEPTH));

endmodule

// File: tb/tb_fifo_ptr_ctrl_drop.sv
module tb_fifo_ptr_ctrl_drop;

  localparam int unsigned DEPTH = 10;
  localparam int unsigned AF    = DEPTH - 2;
  localparam int unsigned LAP   = 16;  // weight of the lap bit (ADDR_W = 4)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, rd_ready, drop_valid, drop_all, flush;
  logic [3:0] drop_count;
  logic       wr_ready, rd_valid, full, empty, almost_full, drop_done;
  logic [3:0] wr_addr, rd_addr, count, dropped_cnt;
  logic [4:0] wr_ptr, rd_ptr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: absolute entry indices written/read, taken mod 2*DEPTH.
  int unsigned m_w, m_r, m_cnt, m_dropped;
  bit          m_done;

  fifo_ptr_ctrl_drop #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .drop_valid  (drop_valid),
    .drop_all    (drop_all),
    .drop_count  (drop_count),
    .flush       (flush),
    .wr_addr     (wr_addr),
    .rd_addr     (rd_addr),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .drop_done   (drop_done),
    .dropped_cnt (dropped_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned exp_ptr(input int unsigned a);
    return ((a / DEPTH) % 2) * LAP + (a % DEPTH);
  endfunction

  task automatic check_regs();
    check("wr_ptr", wr_ptr, exp_ptr(m_w));
    check("rd_ptr", rd_ptr, exp_ptr(m_r));
    check("wr_addr", wr_addr, m_w % DEPTH);
    check("rd_addr", rd_addr, m_r % DEPTH);
    check("count", count, m_cnt);
    check("full", full, m_cnt == DEPTH);
    check("empty", empty, m_cnt == 0);
    check("almost_full", almost_full, m_cnt >= AF);
    check("drop_done", drop_done, m_done);
    if (m_done) check("dropped_cnt", dropped_cnt, m_dropped);
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    wr_valid   = 1'($urandom_range(0, 1));
    rd_ready   = 1'($urandom_range(0, 1));
    drop_valid = 1'($urandom_range(0, 1));
    drop_all   = 1'($urandom_range(0, 1));
    drop_count = 4'($urandom_range(0, 15));
    flush      = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_w = 0; m_r = 0; m_cnt = 0; m_done = 0; m_dropped = 0;
    check_regs();
    check("rst_dropped_cnt", dropped_cnt, 0);
  endtask

  task automatic step(input bit wv, input bit rr, input bit dv, input bit da,
                      input int unsigned dc, input bit fl);
    bit          wf, rf, ewr, erd;
    int unsigned d;
    wr_valid   = wv;
    rd_ready   = rr;
    drop_valid = dv;
    drop_all   = da;
    drop_count = 4'(dc);
    flush      = fl;
    #1;
    ewr = (m_cnt != DEPTH) && !fl;
    erd = (m_cnt != 0) && !fl && !dv;
    check("wr_ready", wr_ready, ewr);
    check("rd_valid", rd_valid, erd);
    wf = wv && ewr;
    rf = rr && erd;
    @(posedge clk);
    #1;
    if (fl) begin
      m_w = 0; m_r = 0; m_cnt = 0; m_done = 0; m_dropped = 0;
    end else begin
      d = 0;
      if (dv) begin
        d = da ? m_cnt : ((dc < m_cnt) ? dc : m_cnt);
        m_r       = (m_r + d) % (2 * DEPTH);
        m_done    = 1;
        m_dropped = d;
      end else begin
        m_done = 0;
        if (rf) m_r = (m_r + 1) % (2 * DEPTH);
      end
      if (wf) m_w = (m_w + 1) % (2 * DEPTH);
      m_cnt = m_cnt + (wf ? 1 : 0) - (rf ? 1 : 0) - d;
    end
    check_regs();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr_valid = 0; rd_ready = 0; drop_valid = 0; drop_all = 0; drop_count = 0; flush = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Fill from reset, then one write beyond full.
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0);
    check("fill_wr_ptr", wr_ptr, 5'h10);
    check("fill_full", full, 1);
    step(1, 0, 0, 0, 0, 0);
    check("overfill_wr_ptr", wr_ptr, 5'h10);
    check("overfill_count", count, 10);

    // One entry in flight across several laps.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      step(1, 1, 0, 0, 0, 0);
      check("wr_lo_range", wr_ptr[3:0] < 4'd10, 1);
      check("rd_lo_range", rd_ptr[3:0] < 4'd10, 1);
    end
    step(0, 1, 0, 0, 0, 0);
    check("pairs_rd_ptr", rd_ptr, 5'h05);
    check("pairs_empty", empty, 1);

    // Oversized drop count is clamped to occupancy.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 15, 0);
    check("clamp_dropped", dropped_cnt, 6);
    check("clamp_done", drop_done, 1);
    check("clamp_empty", empty, 1);
    step(0, 0, 0, 0, 0, 0);
    check("clamp_done_off", drop_done, 0);

    // Drop by count with a same-cycle write.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 2, 0);
    check("dropn_count", count, 3);
    check("dropn_rd_ptr", rd_ptr, 2);
    check("dropn_wr_ptr", wr_ptr, 5);

    // Drop all with a same-cycle write.
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    check("dall_rd_ptr", rd_ptr, 7);
    check("dall_count", count, 1);
    check("dall_dropped", dropped_cnt, 7);

    // Flush beats a same-cycle write and drop.
    step(1, 1, 1, 0, 3, 1);
    check("flush_wr_ptr", wr_ptr, 0);
    check("flush_rd_ptr", rd_ptr, 0);
    check("flush_done", drop_done, 0);

    // Back-to-back drops keep drop_done high.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    check("b2b_done", drop_done, 1);
    check("b2b_count", count, 3);

    // Randomised traffic with occasional mid-traffic reset.
    for (int i = 0; i < 2000; i++) begin
      bit dv;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        dv = $urandom_range(0, 99) < 8;
        step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50, dv,
             dv && ($urandom_range(0, 3) == 0), $urandom_range(0, 15),
             $urandom_range(0, 99) < 3);
      end
    end

    // Reset mid-traffic returns everything to reset values.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    do_reset();
    check("mid_rst_empty", empty, 1);
    check("mid_rst_done", drop_done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
